hilo_muldiv_unit: RTL and testbench

- Execute-stage consumer of the 21-bit control word produced by the instruction decoder, for the HI/LO subset of instructions: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Owns the architectural HI and LO registers.
- Runs an iterative radix-2 multiply or restoring divide over XLEN cycles and stalls the pipeline while busy.

---
 rtl/hilo_muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner with an iterative radix-2 multiplier and restoring divider (XLEN steps each).
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
`ifndef ALU_MUL
`define ALU_MUL 4'b1001
`endif
`ifndef ALU_DIV
`define ALU_DIV 4'b1010
`endif

module hilo_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [20:0]     control_word,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_valid,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic [3:0] aluop;
  logic       is_uns, mul_op, div_op, muldiv_op, mthi, mtlo, mfhi, mflo, hilo_op;
  logic       rs_neg, rt_neg;

  assign aluop     = control_word[7:4];
  assign is_uns    = control_word[16];
  assign mul_op    = start && (aluop == `ALU_MUL);
  assign div_op    = start && (aluop == `ALU_DIV);
  assign muldiv_op = mul_op || div_op;
  assign mthi      = start && control_word[20] && !control_word[19];
  assign mtlo      = start && control_word[18] && !control_word[17];
  assign mfhi      = start && control_word[19] && !control_word[20];
  assign mflo      = start && control_word[17] && !control_word[18];
  assign hilo_op   = muldiv_op || mthi || mtlo || mfhi || mflo;
  assign rs_neg    = !is_uns && rs_data[XLEN-1];
  assign rt_neg    = !is_uns && rt_data[XLEN-1];

  logic                  is_div_q, res_neg_q, rem_neg_q;
  logic signed [XLEN-1:0] opb_q;
  logic [XLEN-1:0]       mplier_q, acc_hi_q, acc_lo_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  latch, last_step;

  assign latch = (state == IDLE) && muldiv_op;

  // Iteration step: multiply adds then shifts right; divide shifts left, trial-subtracts, restores
  logic [XLEN:0]   mul_sum, rem_sh;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (mplier_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    rem_sh  = {acc_hi_q, acc_lo_q[XLEN-1]};
    diff    = {1'b0, rem_sh} - {2'b00, opb_q};
    if (is_div_q) begin
      if (diff[XLEN+1]) begin
        step_hi = rem_sh[XLEN-1:0];
        step_lo = {acc_lo_q[XLEN-2:0], 1'b0};
      end else begin
        step_hi = diff[XLEN-1:0];
        step_lo = {acc_lo_q[XLEN-2:0], 1'b1};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{control_word[15:8], control_word[3:0], diff[XLEN]};

`ifdef MULDIV_EARLY_OUT_EN
  assign last_step = (cnt_q == CNT_W'(XLEN-1)) || (!is_div_q && (mplier_q[XLEN-1:1] == '0));
`else
  assign last_step = (cnt_q == CNT_W'(XLEN-1));
`endif

  // Sign correction of the unsigned result; an early-out product is realigned first
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   res_hi, res_lo;

  always_comb begin
    prod = {acc_hi_q, acc_lo_q};
`ifdef MULDIV_EARLY_OUT_EN
    prod = prod >> (CNT_W'(XLEN) - cnt_q);
`endif
    prod_fix = res_neg_q ? -prod : prod;
    if (is_div_q) begin
      res_lo = res_neg_q ? -acc_lo_q : acc_lo_q;
      res_hi = rem_neg_q ? -acc_hi_q : acc_hi_q;
    end else begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      is_div_q  <= div_op;
      res_neg_q <= (rs_neg ^ rt_neg) && (rt_data != '0);
      rem_neg_q <= rs_neg;
      opb_q     <= div_op ? magnitude(rt_data, rt_neg) : magnitude(rs_data, rs_neg);
      mplier_q  <= magnitude(rt_data, rt_neg);
      acc_hi_q  <= '0;
      acc_lo_q  <= div_op ? magnitude(rs_data, rs_neg) : '0;
      cnt_q     <= '0;
    end else if (state == CALC) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE:    if (muldiv_op) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) stall = hilo_op;
  end

  logic [XLEN-1:0] hi_q, lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == FIX) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if ((state == IDLE) && !muldiv_op) begin
      if (mthi) hi_q <= rs_data;
      if (mtlo) lo_q <= rs_data;
    end
  end

  always_comb begin
    rd_valid = (state == IDLE) && !muldiv_op && (mfhi || mflo);
    rd_data  = '0;
    if (rd_valid) rd_data = mfhi ? hi_q : lo_q;
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;
  localparam int XLEN = 32;
`ifdef ALU_MUL
  localparam logic [3:0] OP_MUL = `ALU_MUL;
`else
  localparam logic [3:0] OP_MUL = 4'b1001;
`endif
`ifdef ALU_DIV
  localparam logic [3:0] OP_DIV = `ALU_DIV;
`else
  localparam logic [3:0] OP_DIV = 4'b1010;
`endif
  localparam logic [3:0] OP_ADD = 4'b0000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [20:0]     control_word;
  logic [XLEN-1:0] rs_data, rt_data;
  logic            stall, done, rd_valid;
  logic [XLEN-1:0] rd_data, hi_out, lo_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] cw_mult, cw_multu, cw_div, cw_divu, cw_mthi, cw_mtlo, cw_mfhi, cw_mflo, cw_add;

  hilo_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .control_word(control_word),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [20:0] cw(input logic hw, hr, lw, lr, uns, input logic [3:0] op);
    logic [20:0] c;
    c = '0;
    c[20] = hw; c[19] = hr; c[18] = lw; c[17] = lr; c[16] = uns;
    c[7:4] = op;
    return c;
  endfunction

  task automatic model(input logic is_div, uns, input logic [31:0] a, b,
                       output logic [31:0] eh, el);
    longint sa, sb, p, q, r;
    sa = uns ? longint'(a) : longint'($signed(a));
    sb = uns ? longint'(b) : longint'($signed(b));
    if (!is_div) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endtask

  function automatic int exp_lat(input logic is_div, uns, input logic [31:0] b);
    int steps, mul_steps, early;
    logic [31:0] m;
    early = 0;
`ifdef MULDIV_EARLY_OUT_EN
    early = 1;
`endif
    m = (!uns && b[31]) ? -b : b;
    mul_steps = 1;
    for (int i = 0; i < XLEN; i++) if (m[i]) mul_steps = i + 1;
    steps = (early != 0 && !is_div) ? mul_steps : XLEN;
    return steps + 2;
  endfunction

  // Issues op for one cycle, then holds f_cw (with fa/fb) until one cycle after the expected DONE.
  task automatic run_op(input string name, input logic [20:0] op_cw, input logic [31:0] a, b,
                        input logic [20:0] f_cw, input logic [31:0] fa, fb, output int dcyc);
    logic        is_div, uns, f_mf, f_hilo, f_hi;
    logic [31:0] eh, el, hi_d, lo_d, rd_v;
    int          lat, n_done, stall_err, rdv_err;
    is_div = (op_cw[7:4] == OP_DIV);
    uns    = op_cw[16];
    model(is_div, uns, a, b, eh, el);
    lat    = exp_lat(is_div, uns, b);
    f_hi   = f_cw[19] && !f_cw[20];
    f_mf   = f_hi || (f_cw[17] && !f_cw[18]);
    f_hilo = f_mf || (f_cw[7:4] == OP_MUL) || (f_cw[7:4] == OP_DIV);
    hi_d = 'x; lo_d = 'x; rd_v = 'x;
    dcyc = -1; n_done = 0; stall_err = 0; rdv_err = 0;

    @(posedge clk); #1;
    start = 1'b1; control_word = op_cw; rs_data = a; rt_data = b;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s issue: stall=%b done=%b, expected 0 0", name, stall, done);
    end
    @(posedge clk); #1;
    control_word = f_cw; rs_data = fa; rt_data = fb;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (dcyc < 0) begin dcyc = c; hi_d = hi_out; lo_d = lo_out; end
      end else if (done !== 1'b0) n_done += 100;
      if (stall !== (f_hilo && c <= lat)) stall_err++;
      if (rd_valid !== (f_mf && c == lat + 1)) rdv_err++;
      if (c == lat + 1) rd_v = rd_data;
      @(posedge clk); #1;
    end

    n_checks++;
    if (dcyc != lat) begin
      n_fail++; $display("FAIL %s latency: got %0d cycles, expected %0d", name, dcyc, lat);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d, expected 1", name, n_done);
    end
    n_checks++;
    if (hi_d !== eh) begin
      n_fail++; $display("FAIL %s hi: got %h, expected %h", name, hi_d, eh);
    end
    n_checks++;
    if (lo_d !== el) begin
      n_fail++; $display("FAIL %s lo: got %h, expected %h", name, lo_d, el);
    end
    n_checks++;
    if (stall_err != 0) begin
      n_fail++; $display("FAIL %s stall: %0d wrong cycles, expected 0", name, stall_err);
    end
    n_checks++;
    if (rdv_err != 0) begin
      n_fail++; $display("FAIL %s rd_valid: %0d wrong cycles, expected 0", name, rdv_err);
    end
    if (f_mf) begin
      n_checks++;
      if (rd_v !== (f_hi ? eh : el)) begin
        n_fail++; $display("FAIL %s rd_data: got %h, expected %h", name, rd_v, f_hi ? eh : el);
      end
    end
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, el);
    n_checks++;
    if (hi_out !== eh || lo_out !== el) begin
      n_fail++;
      $display("FAIL %s const: got hi=%h lo=%h, expected hi=%h lo=%h", name, hi_out, lo_out, eh, el);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; control_word = '0; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    check_hilo("reset", 32'd0, 32'd0);
    n_checks++;
    if (stall !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset outputs: stall=%b done=%b rd_valid=%b rd_data=%h, expected all 0",
               stall, done, rd_valid, rd_data);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: done=%b stall=%b, expected 0 0", done, stall);
    end
  endtask

  task automatic test_mtmf();
    @(posedge clk); #1;
    start = 1'b1; control_word = cw_mthi; rs_data = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi stall: got %b, expected 0", stall); end
    @(posedge clk); #1;
    control_word = cw_mfhi; rs_data = 32'd0;
    @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b1 || stall !== 1'b0 || rd_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mfhi read: rd_valid=%b stall=%b rd_data=%h, expected 1 0 12345678",
               rd_valid, stall, rd_data);
    end
    @(posedge clk); #1;
    control_word = cw_mtlo; rs_data = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    control_word = cw_mflo; rs_data = 32'd0;
    @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b1 || stall !== 1'b0 || rd_data !== 32'h9ABC_DEF0) begin
      n_fail++;
      $display("FAIL mflo read: rd_valid=%b stall=%b rd_data=%h, expected 1 0 9abcdef0",
               rd_valid, stall, rd_data);
    end
    check_hilo("mtmf_regs", 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_multiply();
    int d;
    run_op("mult_m2x3", cw_mult, 32'hFFFF_FFFE, 32'd3, cw_mfhi, 32'd0, 32'd0, d);
    start = 1'b0;
    check_hilo("mult_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", cw_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cw_mflo, 32'd0, 32'd0, d);
    start = 1'b0;
    check_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("multu_x3", cw_multu, 32'hFFFF_FFFF, 32'd3, cw_mfhi, 32'd0, 32'd0, d);
    start = 1'b0;
    check_hilo("multu_x3", 32'h0000_0002, 32'hFFFF_FFFD);
`ifdef MULDIV_EARLY_OUT_EN
    n_checks++;
    if (d > 5 || d < 1) begin
      n_fail++; $display("FAIL multu_x3 early_out: done after %0d cycles, expected at most 5", d);
    end
`endif
  endtask

  task automatic test_divide();
    int d;
    run_op("div_m7_2", cw_div, 32'hFFFF_FFF9, 32'd2, cw_mflo, 32'd0, 32'd0, d);
    start = 1'b0;
    check_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", cw_divu, 32'd100, 32'd0, cw_mflo, 32'd5, 32'd6, d);
    start = 1'b0;
    check_hilo("divu_by0", 32'd100, 32'hFFFF_FFFF);
    run_op("div_ovf", cw_div, 32'h8000_0000, 32'hFFFF_FFFF, cw_mfhi, 32'd0, 32'd0, d);
    start = 1'b0;
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);
    run_op("div_neg_by0", cw_div, 32'hFFFF_FF00, 32'd0, cw_mfhi, 32'd0, 32'd0, d);
    start = 1'b0;
  endtask

  task automatic test_nonhilo();
    int d;
    run_op("mult_with_add", cw_mult, 32'd12345, 32'hFFFF_FF85, cw_add, 32'hDEAD_BEEF, 32'd77, d);
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; control_word = cw_add;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_idle: stall=%b rd_valid=%b, expected 0 0", stall, rd_valid);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d, got, lat2;
    logic [31:0] eh, el;
    run_op("b2b_first", cw_mult, 32'h0001_0003, 32'hFFFF_0007, cw_divu, 32'd1000, 32'd7, d);
    start = 1'b0;
    model(1'b1, 1'b1, 32'd1000, 32'd7, eh, el);
    lat2 = exp_lat(1'b1, 1'b1, 32'd7);
    got = -1;
    for (int c = 1; c <= lat2 + 3 && got < 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = c;
        check_hilo("b2b_second", eh, el);
      end
    end
    n_checks++;
    if (got != lat2) begin
      n_fail++; $display("FAIL b2b_second latency: got %0d, expected %0d", got, lat2);
    end
  endtask

  task automatic test_reset_midop();
    int d, n_done;
    @(posedge clk); #1;
    start = 1'b1; control_word = cw_mthi; rs_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    control_word = cw_mult; rs_data = 32'd7; rt_data = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_hilo("reset_midop", 32'd0, 32'd0);
    n_checks++;
    if (done !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_midop outputs: done=%b stall=%b, expected 0 0", done, stall);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; control_word = cw_mfhi;
    @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b1 || stall !== 1'b0 || rd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_midop idle: rd_valid=%b stall=%b rd_data=%h, expected 1 0 0",
               rd_valid, stall, rd_data);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++; $display("FAIL reset_midop done: %0d pulses, expected 0", n_done);
    end
    run_op("post_reset_mult", cw_mult, 32'hFFFF_FFF0, 32'h0000_1234, cw_mflo, 32'd0, 32'd0, d);
    start = 1'b0;
  endtask

  task automatic test_random();
    int d;
    logic [20:0] ocw, fcw;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       ocw = cw_mult;
        1:       ocw = cw_multu;
        2:       ocw = cw_div;
        default: ocw = cw_divu;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'(-$urandom_range(1, 15));
        1:       b = 32'($urandom_range(0, 15));
        2:       b = 32'd0;
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      fcw = $urandom_range(0, 1) ? cw_mfhi : cw_mflo;
      run_op($sformatf("rand%0d", i), ocw, a, b, fcw, $urandom, $urandom, d);
      start = 1'b0;
    end
  endtask

  initial begin
    cw_mult  = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_MUL);
    cw_multu = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, OP_MUL);
    cw_div   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_DIV);
    cw_divu  = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, OP_DIV);
    cw_mthi  = cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OP_ADD);
    cw_mtlo  = cw(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, OP_ADD);
    cw_mfhi  = cw(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OP_ADD);
    cw_mflo  = cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OP_ADD);
    cw_add   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OP_ADD) | 21'h00_0A05;

    test_reset();
    test_mtmf();
    test_multiply();
    test_divide();
    test_nonhilo();
    test_back_to_back();
    test_reset_midop();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
